// File: rtl/message_tx_frame_serializer.sv
// message_tx_frame_serializer
// Latches UTC time on a start strobe, builds {header, hour, minute, second} with an
// optional trailing CRC-8, and shifts the frame out MSB-first, one bit per bit_en strobe.
// One extra bit_en after the last bit closes that bit's period before frame_done pulses.
module message_tx_frame_serializer #(
    parameter int               HDR_W     = 103,
    parameter logic [HDR_W-1:0] HDR_VALUE = 103'h5a5a5a5a_5a5a5a5a,
    parameter bit               CRC_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        sys_utc_time_hour,
    input  logic [5:0]        sys_utc_time_minute,
    input  logic [5:0]        sys_utc_time_second,
    input  logic              start,
    input  logic              bit_en,
    output logic [HDR_W+16:0] message_o,
    output logic              data_o,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              time_err,
    output logic              overrun
);

    localparam int DATA_W  = HDR_W + 17;
    localparam int FRAME_W = DATA_W + (CRC_EN ? 8 : 0);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // bit_cnt value while the last header/time bit is being sent
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(DATA_W - 1);
    // bit_cnt value once every frame bit is out; the next bit_en ends the frame
    localparam logic [CNT_W-1:0] FINAL_CNT     = CNT_W'(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CRC,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                shift_data;
    logic                shift_crc;
    logic [DATA_W-1:0]   frame_word;
    logic [DATA_W-1:0]   sreg;
    logic [7:0]          crc;
    logic [CNT_W-1:0]    bit_cnt;

    // CRC-8, polynomial 0x07, MSB-first, one message bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
        logic fb;
        fb = crc_in[7] ^ bit_in;
        return {crc_in[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Legal UTC time: hour 0..23, minute 0..59, second 0..59
    function automatic logic time_in_range(input logic [4:0] hh, input logic [5:0] mm,
                                           input logic [5:0] ss);
        return (hh <= 5'd23) && (mm <= 6'd59) && (ss <= 6'd59);
    endfunction

    assign frame_word = {HDR_VALUE, sys_utc_time_hour, sys_utc_time_minute, sys_utc_time_second};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift_data = 1'b0;
        shift_crc  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                // bit_en is not looked at here, so a coincident start always wins
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (bit_en) begin
                    if (bit_cnt == FINAL_CNT) begin
                        // only reachable without CRC: closing strobe after the last data bit
                        state_next = S_DONE;
                    end else begin
                        shift_data = 1'b1;
                        if (CRC_EN && (bit_cnt == LAST_DATA_CNT)) begin
                            state_next = S_CRC;
                        end
                    end
                end
            end
            S_CRC: begin
                busy = 1'b1;
                if (bit_en) begin
                    if (bit_cnt == FINAL_CNT) begin
                        state_next = S_DONE;
                    end else begin
                        shift_crc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame latch, shift register, CRC accumulator, serial output and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            message_o <= '0;
            sreg      <= '0;
            crc       <= 8'h00;
            bit_cnt   <= '0;
            data_o    <= 1'b0;
            bit_valid <= 1'b0;
            time_err  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (accept) begin
                message_o <= frame_word;
                sreg      <= frame_word;
                time_err  <= !time_in_range(sys_utc_time_hour, sys_utc_time_minute,
                                            sys_utc_time_second);
                bit_cnt   <= '0;
            end
            if (state == S_LOAD) begin
                crc <= 8'h00;
            end
            if (shift_data) begin
                data_o    <= sreg[DATA_W-1];
                sreg      <= {sreg[DATA_W-2:0], 1'b0};
                crc       <= crc8_step(crc, sreg[DATA_W-1]);
                bit_cnt   <= bit_cnt + 1'b1;
                bit_valid <= 1'b1;
            end
            if (shift_crc) begin
                data_o    <= crc[7];
                crc       <= {crc[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
                bit_valid <= 1'b1;
            end
            // last bit is held through the closing strobe, then the line idles low
            if (state == S_DONE) begin
                data_o <= 1'b0;
            end
            // any start outside IDLE (including the DONE cycle) is dropped and remembered
            if (start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
